atm_light_est_20b: RTL

- Streaming stage directly downstream of the per-pixel 3-input 20-bit maximum block of the haze-removal pipeline.
- Consumes one 20-bit value per pixel in raster order over a frame.
- Tracks the frame-wide maximum and the (x,y) position of its first occurrence.
- Presents the result with a valid/ready handshake; the atmospheric-light estimator consumes it.

---
 rtl/atm_light_est_20b.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/atm_light_est_20b.sv
`default_nettype none
// ============================================================================
// Module      : atm_light_est_20b
// Description : Frame-wide maximum tracker with first-occurrence (x,y) and a
//               valid/ready result hold, feeding the atmospheric-light stage.
// Revision    : 1.0 - initial release
// ============================================================================
module atm_light_est_20b #(
  parameter int DATA_W = 20,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int X_W    = 10,
  parameter int Y_W    = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sof,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_max,
  output logic [X_W-1:0]    out_x,
  output logic [Y_W-1:0]    out_y,
  output logic              frame_err
);

  localparam logic [X_W-1:0] C_LAST_X  = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0] C_LAST_Y  = Y_W'(IMG_H - 1);
  localparam logic [X_W-1:0] C_START_X = X_W'((IMG_W == 1) ? 0 : 1);
  localparam logic [Y_W-1:0] C_START_Y = Y_W'((IMG_W == 1) ? 1 : 0);
  localparam bit             C_SINGLE  = (IMG_W * IMG_H == 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] cur_max, cur_max_n;
  logic [X_W-1:0]    max_x, max_x_n, col, col_n;
  logic [Y_W-1:0]    max_y, max_y_n, row, row_n;
  logic              load, err_n;
  logic [DATA_W-1:0] res_max;
  logic [X_W-1:0]    res_x;
  logic [Y_W-1:0]    res_y;
  logic              accept, upd, last_pix;

  assign in_ready  = (state != S_HOLD);
  assign out_valid = (state == S_HOLD);
  assign accept    = in_valid & in_ready;
  assign upd       = (in_data > cur_max);
  assign last_pix  = (col == C_LAST_X) && (row == C_LAST_Y);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    cur_max_n = cur_max;
    max_x_n   = max_x;
    max_y_n   = max_y;
    col_n     = col;
    row_n     = row;
    err_n     = 1'b0;
    load      = 1'b0;
    res_max   = cur_max;
    res_x     = max_x;
    res_y     = max_y;
    case (state)
      S_IDLE, S_ACCUM: begin
        if (accept && in_sof) begin
          // A start-of-frame always restarts, even mid-frame.
          err_n     = (state == S_ACCUM);
          cur_max_n = in_data;
          max_x_n   = '0;
          max_y_n   = '0;
          col_n     = C_START_X;
          row_n     = C_START_Y;
          res_max   = in_data;
          res_x     = '0;
          res_y     = '0;
          if (C_SINGLE) begin
            load    = 1'b1;
            state_n = S_HOLD;
          end else begin
            state_n = S_ACCUM;
          end
        end else if (accept && state == S_ACCUM) begin
          if (upd) begin
            cur_max_n = in_data;
            max_x_n   = col;
            max_y_n   = row;
          end
          res_max = cur_max_n;
          res_x   = max_x_n;
          res_y   = max_y_n;
          if (last_pix) begin
            load    = 1'b1;
            state_n = S_HOLD;
          end else if (col == C_LAST_X) begin
            col_n = '0;
            row_n = row + 1'b1;
          end else begin
            col_n = col + 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (out_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_max   <= '0;
      max_x     <= '0;
      max_y     <= '0;
      col       <= '0;
      row       <= '0;
      frame_err <= 1'b0;
      out_max   <= '0;
      out_x     <= '0;
      out_y     <= '0;
    end else begin
      cur_max   <= cur_max_n;
      max_x     <= max_x_n;
      max_y     <= max_y_n;
      col       <= col_n;
      row       <= row_n;
      frame_err <= err_n;
      if (load) begin
        out_max <= res_max;
        out_x   <= res_x;
        out_y   <= res_y;
      end
    end
  end

endmodule
`default_nettype wire
